// File: rtl/id_stage_if.sv
// Fetch/decode bus: instruction and PC from fetch,
// stall and redirect controls back to fetch.
interface id_stage_if;
  logic [31:0] Instruction_if;
  logic [31:0] PC_if;
  logic        IFWrite;
  logic        Branch;
  logic        Jump;
  logic [31:0] JumpAddr;
  logic        IF_flush;

  modport master (
    output Instruction_if,
    output PC_if,
    input  IFWrite,
    input  Branch,
    input  Jump,
    input  JumpAddr,
    input  IF_flush
  );

  modport slave (
    input  Instruction_if,
    input  PC_if,
    output IFWrite,
    output Branch,
    output Jump,
    output JumpAddr,
    output IF_flush
  );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, GPR file,
// hazard detection and beq/bne/j resolution.
module id_stage #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        reset,
  id_stage_if.slave   fe,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic [4:0]  WriteReg_ex,
  input  logic        RegWrite_mem,
  input  logic [4:0]  WriteReg_mem,
  input  logic        RegWrite_wb,
  input  logic [4:0]  WriteReg_wb,
  input  logic [31:0] WriteData_wb,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id,
  output logic [31:0] RsData_id,
  output logic [31:0] RtData_id,
  output logic [31:0] Imm_id
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] gpr_q [NREG];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        is_br;
  logic        stall;
  logic        br_d;
  logic        jmp_d;
  logic [31:0] jaddr_d;
  logic [31:0] pc4;

  assign op  = instr_q[31:26];
  assign rs  = instr_q[25:21];
  assign rt  = instr_q[20:16];
  assign pc4 = pc_q + 32'd4;

  assign is_br = (op == 6'h04) || (op == 6'h05);

  function automatic logic [31:0] rd_gpr(
    input logic [4:0] a
  );
    if (a == 5'd0)
      return 32'd0;
    else if (RegWrite_wb && WriteReg_wb == a)
      return WriteData_wb;
    else
      return gpr_q[a];
  endfunction

  // IF/ID register: reset > flush > write-enable > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (fe.IF_flush) begin
      instr_q <= '0;
      pc_q    <= fe.PC_if;
    end else if (fe.IFWrite) begin
      instr_q <= fe.Instruction_if;
      pc_q    <= fe.PC_if;
    end
  end

  // GPR file; $0 never written, writes proceed during stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        gpr_q[i] <= '0;
    end else if (RegWrite_wb && WriteReg_wb != 5'd0) begin
      gpr_q[WriteReg_wb] <= WriteData_wb;
    end
  end

  // Hazard check and control-transfer resolution
  always_comb begin
    stall   = 1'b0;
    br_d    = 1'b0;
    jmp_d   = 1'b0;
    jaddr_d = '0;
    if (MemRead_ex && WriteReg_ex != 5'd0 &&
        (WriteReg_ex == rs || WriteReg_ex == rt))
      stall = 1'b1;
    if (is_br && RegWrite_ex && WriteReg_ex != 5'd0 &&
        (WriteReg_ex == rs || WriteReg_ex == rt))
      stall = 1'b1;
    if (is_br && RegWrite_mem && WriteReg_mem != 5'd0 &&
        (WriteReg_mem == rs || WriteReg_mem == rt))
      stall = 1'b1;
    if (!stall) begin
      unique case (1'b1)
        op == 6'h04: br_d = (RsData_id == RtData_id);
        op == 6'h05: br_d = (RsData_id != RtData_id);
        op == 6'h02: jmp_d = 1'b1;
        default: ;
      endcase
    end
    if (br_d)
      jaddr_d = pc4 + {Imm_id[29:0], 2'b00};
    else if (jmp_d)
      jaddr_d = {pc4[31:28], instr_q[25:0], 2'b00};
  end

  assign RsData_id = rd_gpr(rs);
  assign RtData_id = rd_gpr(rt);
  assign Imm_id    = {{16{instr_q[15]}}, instr_q[15:0]};

  assign Instruction_id = instr_q;
  assign PC_id          = pc_q;

  assign fe.IFWrite  = !stall;
  assign fe.Branch   = br_d;
  assign fe.Jump     = jmp_d;
  assign fe.JumpAddr = jaddr_d;
  assign fe.IF_flush = br_d | jmp_d;

endmodule
